// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_queue
// Description : Instruction-fetch stage. It owns the fetch PC and issues
//               in-order byte reads to program memory. Returned bytes are
//               queued with their PC in a small prefetch FIFO and handed to
//               the control unit one per cycle. A redirect flushes the
//               queue and drops stale in-flight responses.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  // program-memory request channel
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  // program-memory response channel (in order, one per accepted request)
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  // flow control from the control unit
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  // instruction hand-off to the control unit
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_fetch_pc;
  // PC belonging to the next response that will actually be queued
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_inflight;
  logic [CW-1:0]     r_discard;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc   [DEPTH];

  logic [CW:0]       w_used;
  logic              w_credit_ok;
  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_rsp_fire;
  logic              w_drop;
  logic              w_enq;
  logic              w_deq;
  logic              w_full;

  // Slots already promised: queued entries plus responses still owed.
  assign w_used      = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_credit_ok = (w_used < (CW+1)'(DEPTH));
  assign w_full      = (r_count == CW'(DEPTH));

  assign w_req_fire  = mem_req_valid & mem_req_ready;
  assign w_rsp_fire  = mem_rsp_valid;
  assign w_drop      = (r_discard != '0);
  // A redirect flushes the queue, so nothing enters or leaves it that cycle.
  assign w_enq       = w_rsp_fire & ~w_drop & ~redirect_valid;
  assign w_deq       = instr_valid & instr_ready & ~redirect_valid;

  assign mem_req_valid = w_req_valid & ~rst;
  assign mem_req_addr  = r_fetch_pc;
  assign instr_valid   = (r_count != '0);
  assign instr_data    = r_fifo_data[r_rd_ptr];
  assign instr_pc      = r_fifo_pc[r_rd_ptr];

  // State register for the run/halt controller.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and request enable; a redirect always restarts fetching.
  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_req_valid = w_credit_ok & ~redirect_valid;
        if (halt_req) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        w_req_valid = 1'b0;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
    if (redirect_valid) begin
      w_state_nxt = ST_RUN;
    end
  end

  // Fetch PC advances on each accepted request, or jumps on redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_req_fire) begin
      r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
    end
  end

  // Response PC follows the fetch PC, lagging by the kept in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_rsp_pc <= redirect_pc;
    end else if (w_enq) begin
      r_rsp_pc <= r_rsp_pc + ADDR_W'(1);
    end
  end

  // In-flight and discard bookkeeping for outstanding memory reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
      r_discard  <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_fire);
      if (redirect_valid) begin
        // Every read still owed after this cycle belongs to the old flow,
        // including any already marked stale by an earlier redirect.
        r_discard <= r_inflight - CW'(w_rsp_fire);
      end else if (w_rsp_fire && w_drop) begin
        r_discard <= r_discard - CW'(1);
      end
    end
  end

  // Prefetch FIFO pointers, occupancy and storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_fifo_data[r_wr_ptr] <= mem_rsp_data;
        r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
        r_wr_ptr              <= r_wr_ptr + PW'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

`ifndef SYNTHESIS
  // The credit scheme never lets a kept response arrive into a full queue
  // unless the head leaves in the same cycle.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(w_enq && w_full && !w_deq));
`endif

endmodule
`default_nettype wire
